pg_preprocess_stage: RTL

PG_PREPROCESS_STAGE -- requirements
Module: pg_preprocess_stage

---
 rtl/pg_preprocess_stage_pkg.sv | 16 +
 rtl/pg_preprocess_stage_if.sv | 29 ++
 rtl/pg_preprocess_stage_pg_bit.sv | 10 +
 rtl/pg_preprocess_stage.sv | 119 +++++++++++
 4 files changed

// File: rtl/pg_preprocess_stage_pkg.sv
// Shared adder definitions: buffer state encoding, default width, gray-cell generate.
package pg_preprocess_stage_pkg;

   localparam int unsigned DEFAULT_WIDTH = 16;
   localparam int unsigned STATE_W       = 2;

   localparam logic [STATE_W-1:0] ST_EMPTY = 2'b00;
   localparam logic [STATE_W-1:0] ST_ONE   = 2'b01;
   localparam logic [STATE_W-1:0] ST_FULL  = 2'b10;

   // Gray cell: group generate from a high (g, p) pair and a lower generate.
   function automatic logic gray_g(input logic g_hi, input logic p_hi, input logic g_lo);
      return g_hi | (p_hi & g_lo);
   endfunction

endpackage

// File: rtl/pg_preprocess_stage_if.sv
// Upstream operand handshake plus downstream g/p handshake of the preprocess stage.
interface pg_preprocess_stage_if
   import pg_preprocess_stage_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   logic             c0;

   // Environment side: offers operands, consumes g/p words.
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, g, p, c0
   );

   // Stage side.
   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, g, p, c0
   );
endinterface

// File: rtl/pg_preprocess_stage_pg_bit.sv
// Single-bit generate/propagate cell.
module pg_bit (
   input  logic a,
   input  logic b,
   output logic g_c,
   output logic p_c
);
   assign g_c = a & b;
   assign p_c = a ^ b;
endmodule

// File: rtl/pg_preprocess_stage.sv
// Prefix-adder preprocess stage: per-bit g/p with carry-in folded into bit 0,
// buffered by a 2-entry skid buffer so in_ready never depends on out_ready.
module pg_preprocess_stage
   import pg_preprocess_stage_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input logic                  clk,
   input logic                  rst,
   pg_preprocess_stage_if.slave bus
);

   logic [STATE_W-1:0] state_q, state_d;
   logic [WIDTH-1:0]   main_g_q, main_g_d, main_p_q, main_p_d;
   logic               main_c0_q, main_c0_d;
   logic [WIDTH-1:0]   skid_g_q, skid_g_d, skid_p_q, skid_p_d;
   logic               skid_c0_q, skid_c0_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;

   logic [WIDTH-1:0]   g_raw_c, p_c, g_c;
   logic               in_xfer_c, out_xfer_c;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pg_bit u_pg_bit (
         .a   (bus.a[i]),
         .b   (bus.b[i]),
         .g_c (g_raw_c[i]),
         .p_c (p_c[i])
      );
   end

   // Fold carry-in into the bit-0 generate.
   always_comb begin
      g_c    = g_raw_c;
      g_c[0] = gray_g(g_raw_c[0], p_c[0], bus.cin);
   end

   assign in_xfer_c  = bus.in_valid & in_ready_q;
   assign out_xfer_c = out_valid_q & bus.out_ready;

   // Next-state and buffer data selection.
   always_comb begin
      state_d   = state_q;
      main_g_d  = main_g_q;
      main_p_d  = main_p_q;
      main_c0_d = main_c0_q;
      skid_g_d  = skid_g_q;
      skid_p_d  = skid_p_q;
      skid_c0_d = skid_c0_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_xfer_c) begin
               main_g_d  = g_c;
               main_p_d  = p_c;
               main_c0_d = bus.cin;
               state_d   = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_xfer_c && out_xfer_c) begin
               main_g_d  = g_c;
               main_p_d  = p_c;
               main_c0_d = bus.cin;
            end else if (in_xfer_c) begin
               skid_g_d  = g_c;
               skid_p_d  = p_c;
               skid_c0_d = bus.cin;
               state_d   = ST_FULL;
            end else if (out_xfer_c) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_xfer_c) begin
               main_g_d  = skid_g_q;
               main_p_d  = skid_p_q;
               main_c0_d = skid_c0_q;
               state_d   = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      in_ready_d  = (state_d != ST_FULL);
      out_valid_d = (state_d != ST_EMPTY);
   end

   // State and buffer registers; reset discards all buffered words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_g_q    <= '0;
         main_p_q    <= '0;
         main_c0_q   <= 1'b0;
         skid_g_q    <= '0;
         skid_p_q    <= '0;
         skid_c0_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_g_q    <= main_g_d;
         main_p_q    <= main_p_d;
         main_c0_q   <= main_c0_d;
         skid_g_q    <= skid_g_d;
         skid_p_q    <= skid_p_d;
         skid_c0_q   <= skid_c0_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.g         = main_g_q;
   assign bus.p         = main_p_q;
   assign bus.c0        = main_c0_q;

endmodule
